fifo_rd_axis: RTL and testbench
===============================

# fifo_rd_axis

Read-side adapter that drains the read port of the dual-clock FIFO and presents its contents as an AXI4-Stream master. It sits entirely in the FIFO read clock domain, between the FIFO (combinational read data, `rempty`, `rinc`) and a downstream AXI4-Stream slave. It has a two-entry output buffer, so it sustains one beat per clock and `m_tdata` is registered. It has no combinational path from `m_tready` to `rinc`.

## Interface
Parameters:
- `DSIZE`, 8: data width; must match the FIFO data width.
- `PKT_LEN`, 16: beats per packet for TLAST generation; must be ≥ 1; used only when the TLAST feature is compiled in.

Ports:
- `rclk`  in  1: read-domain clock; the only clock.
- `rrst`  in  1: asynchronous, active-high reset. It is asserted together with the FIFO read-side reset.
- `rdata`  in  DSIZE: FIFO read data, valid whenever `rempty`=0.
- `rempty`  in  1: FIFO empty flag.
- `rinc`  out  1: FIFO pop strobe.
- `m_tvalid`  out  1: stream valid.
- `m_tready`  in  1: stream ready.
- `m_tdata`  out  DSIZE: stream data.
- `m_tlast`  out  1: end of packet.

## Operation
- Storage is two slots, HEAD and SKID. Each slot holds data plus a last bit.
- An occupancy state machine tracks the slots: S0 (empty), S1 (HEAD valid), S2 (HEAD and SKID valid).
- Pop rule: `rinc` = !`rempty` && state≠S2 && !`rrst`. It depends on registered state and `rempty` only.
- Consume: a beat is consumed when `m_tvalid` && `m_tready`.
- `m_tvalid` = (state≠S0). `m_tdata`/`m_tlast` are driven from HEAD.
- Transitions (push = `rinc`, pop = consume):
  - S0, push: HEAD←rdata, go to S1.
  - S1, push and no pop: SKID←rdata, go to S2.
  - S1, push and pop: HEAD←rdata, stay in S1.
  - S1, pop only: go to S0.
  - S2, pop: HEAD←SKID, go to S1. Push is impossible in S2.
  - Any other combination: hold.
- While `m_tvalid`=1 and `m_tready`=0, `m_tdata`/`m_tlast` hold stable (AXI rule).
- Data leaves in exactly the FIFO read order. No beat is dropped or duplicated.
- If `rempty` rises in the same cycle as a consume in S1, the block goes to S0 and `m_tvalid` deasserts the next cycle.

## Timing
- Reset values: state S0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, beat counter 0. `rinc`=0 while `rrst` is high.
- Latency: a word popped at edge N (`rinc`=1 before N) is on `m_tdata` with `m_tvalid`=1 immediately after edge N.
- Throughput: with `rempty`=0 and `m_tready`=1 held, one beat per clock with no bubbles after the first.
- Backpressure: `m_tready` low for one cycle with the FIFO non-empty takes the block to S2. `rinc` drops on the next cycle and resumes one cycle after `m_tready` returns.
- Reset mid-operation: buffered beats are discarded. The state returns to S0 immediately (asynchronous) and the beat counter returns to 0.

## Configuration
- `FIFO_RD_AXIS_TLAST_EN` defined:
  - A beat counter of width max(1,$clog2(`PKT_LEN`)) increments on every `rinc`.
  - The last bit stored with the pushed word is (counter==`PKT_LEN`-1).
  - The counter wraps to 0 after `PKT_LEN`-1.
  - `PKT_LEN`=1 marks every beat last.
- `FIFO_RD_AXIS_TLAST_EN` undefined: no counter or last bits are built, and `m_tlast` is tied to 0. The port is always present.

## Structure
- Package `fifo_rd_axis_pkg` holds:
  - the occupancy state enum (S0/S1/S2), 2 bits;
  - the counter-width helper function.
- Sub-module `axis_beat_cnt` (parameter `PKT_LEN`; ports `rclk`, `rrst`, `inc`, `last`) is instantiated only under the macro.
- The slot registers and state machine live in the top level.

## Test plan
- Reset, then preload 4 words 0x11..0x14 with `m_tready`=1: `rinc` goes high the cycle after reset release, then 0x11..0x14 appear on consecutive cycles, then `m_tvalid` goes to 0.
- Streaming with `m_tready` low for 3 cycles mid-stream: the state reaches S2, `rinc` stays low, and `m_tdata` holds stable. There is no loss or duplication over 32 beats, checked against a scoreboard.
- `rempty` toggling randomly with `m_tready` toggling randomly for 1000 beats: output order equals input order, and there is no `rinc` in S2.
- With TLAST enabled, `PKT_LEN`=4, 12 beats: `m_tlast` is set on beats 4, 8, 12 only. With `PKT_LEN`=1, every beat has `m_tlast`=1.
- Assert `rrst` while in S2: `m_tvalid`, `m_tdata`, `m_tlast` are 0 immediately. After release, the first beat has counter value 0 (tlast is set after `PKT_LEN` beats).

Source files
------------

// File: rtl/fifo_rd_axis_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_axis_pkg
// Shared types and helpers for the FIFO-read to AXI4-Stream adapter.
//   occ_state_e : output-buffer occupancy (S0 empty, S1 HEAD, S2 HEAD+SKID)
//   cnt_width() : beat-counter width for a given packet length
// No ports. Used by fifo_rd_axis and axis_beat_cnt.
// ----------------------------------------------------------------------------
package fifo_rd_axis_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,  // no slot valid
        S1 = 2'd1,  // HEAD valid
        S2 = 2'd2   // HEAD and SKID valid
    } occ_state_e;

    // max(1, clog2(pkt_len)); PKT_LEN of 1 or 2 still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned pkt_len);
        int unsigned w;
        w = $clog2(pkt_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_rd_axis_if.sv
// ----------------------------------------------------------------------------
// fifo_rd_axis_if
// Bundles the FIFO read port and the AXI4-Stream master port of the adapter.
// Parameter:
//   DSIZE : data width of rdata / m_tdata
// Signals:
//   rdata, rempty : FIFO read data and empty flag (into the adapter)
//   rinc          : FIFO pop strobe (from the adapter)
//   m_tvalid, m_tdata, m_tlast : stream master outputs (from the adapter)
//   m_tready      : stream ready (into the adapter)
// Modports:
//   master : the adapter side (drives rinc and the stream outputs)
//   slave  : the environment side (FIFO plus downstream stream slave)
// ----------------------------------------------------------------------------
interface fifo_rd_axis_if #(
    parameter int unsigned DSIZE = 8
);
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             m_tvalid;
    logic             m_tready;
    logic [DSIZE-1:0] m_tdata;
    logic             m_tlast;

    modport master (
        input  rdata,
        input  rempty,
        input  m_tready,
        output rinc,
        output m_tvalid,
        output m_tdata,
        output m_tlast
    );

    modport slave (
        output rdata,
        output rempty,
        output m_tready,
        input  rinc,
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast
    );
endinterface

// File: rtl/axis_beat_cnt.sv
// ----------------------------------------------------------------------------
// axis_beat_cnt
// Packet beat counter used to generate TLAST. Counts FIFO pops modulo PKT_LEN.
// Parameter:
//   PKT_LEN : beats per packet (>= 1)
// Ports:
//   rclk : clock
//   rrst : asynchronous active-high reset, counter returns to 0
//   inc  : advance the counter (one FIFO pop)
//   last : high while the current count is PKT_LEN-1, i.e. the word being
//          popped now is the final beat of its packet
// ----------------------------------------------------------------------------
module axis_beat_cnt
    import fifo_rd_axis_pkg::*;
#(
    parameter int unsigned PKT_LEN = 16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic inc,
    output logic last
);
    localparam int unsigned     CntW    = cnt_width(PKT_LEN);
    localparam logic [CntW-1:0] LastVal = CntW'(PKT_LEN - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        last  = (cnt_q == LastVal);
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = last ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_rd_axis.sv
// ----------------------------------------------------------------------------
// fifo_rd_axis
// Drains the read port of the dual-clock FIFO and presents it as an
// AXI4-Stream master, entirely in the FIFO read clock domain. A two-slot
// output buffer (HEAD, SKID) sustains one beat per clock with registered
// m_tdata and no combinational path from m_tready to rinc.
// Parameters:
//   DSIZE   : data width, must match the FIFO and the interface DSIZE
//   PKT_LEN : beats per packet for TLAST (only with FIFO_RD_AXIS_TLAST_EN)
// Ports:
//   rclk : read-domain clock
//   rrst : asynchronous active-high reset (shared with FIFO read side)
//   bus  : fifo_rd_axis_if.master (rdata/rempty/rinc, m_tvalid/m_tready/
//          m_tdata/m_tlast)
// Build option:
//   FIFO_RD_AXIS_TLAST_EN : when defined, a beat counter tags every
//   PKT_LEN-th popped word as last; otherwise m_tlast is tied to 0 and no
//   counter or last bits exist.
// ----------------------------------------------------------------------------
module fifo_rd_axis
    import fifo_rd_axis_pkg::*;
#(
    parameter int unsigned DSIZE   = 8,
    parameter int unsigned PKT_LEN = 16
) (
    input  logic           rclk,
    input  logic           rrst,
    fifo_rd_axis_if.master bus
);

    if (PKT_LEN < 1) begin : g_bad_pkt_len
        $error("fifo_rd_axis: PKT_LEN must be >= 1");
    end

`ifdef FIFO_RD_AXIS_TLAST_EN
    // Each slot carries the data word plus its last bit in the MSB.
    localparam int unsigned SlotW = DSIZE + 1;
`else
    localparam int unsigned SlotW = DSIZE;
`endif

    occ_state_e       state_q, state_d;
    logic [SlotW-1:0] head_q, head_d;
    logic [SlotW-1:0] skid_q, skid_d;
    logic [SlotW-1:0] in_word;
    logic             push;
    logic             pop;
    logic             tvalid;

    // Pop decision uses only registered state and rempty, so m_tready never
    // reaches rinc combinationally; S2 simply refuses new words.
    assign push   = !bus.rempty && (state_q != S2) && !rrst;
    assign tvalid = (state_q != S0);
    assign pop    = tvalid && bus.m_tready;

`ifdef FIFO_RD_AXIS_TLAST_EN
    logic push_last;

    axis_beat_cnt #(
        .PKT_LEN (PKT_LEN)
    ) u_beat_cnt (
        .rclk (rclk),
        .rrst (rrst),
        .inc  (push),
        .last (push_last)
    );

    assign in_word     = {push_last, bus.rdata};
    assign bus.m_tlast = head_q[DSIZE];
`else
    assign in_word     = bus.rdata;
    assign bus.m_tlast = 1'b0;
`endif

    assign bus.rinc     = push;
    assign bus.m_tvalid = tvalid;
    assign bus.m_tdata  = head_q[DSIZE-1:0];

    // Occupancy FSM and slot steering. HEAD only changes when it is empty or
    // being consumed, which keeps m_tdata stable under backpressure.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            S0: begin
                if (push) begin
                    head_d  = in_word;
                    state_d = S1;
                end
            end
            S1: begin
                if (push && !pop) begin
                    skid_d  = in_word;
                    state_d = S2;
                end else if (push && pop) begin
                    head_d  = in_word;
                end else if (pop) begin
                    state_d = S0;
                end
            end
            S2: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = S1;
                end
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= S0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_axis.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_axis
// Self-checking bench for fifo_rd_axis. A queue models the FIFO contents; every
// observed pop pushes the word (and its expected last bit) onto a scoreboard,
// every observed consume is checked against the scoreboard head. The
// scoreboard depth doubles as the expected buffer occupancy.
// ----------------------------------------------------------------------------
module tb_fifo_rd_axis;

    localparam int unsigned DSIZE   = 8;
    localparam int unsigned PKT_LEN = 4;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic             last;
    } beat_t;

    typedef struct {
        logic             tready;
        logic             exp_rinc;
        logic             exp_tvalid;
        logic [DSIZE-1:0] exp_tdata;
    } vec_t;

    logic rclk = 1'b0;
    logic rrst;

    always #5 rclk = ~rclk;

    fifo_rd_axis_if #(.DSIZE(DSIZE)) bus ();

    fifo_rd_axis #(
        .DSIZE   (DSIZE),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

`ifdef FIFO_RD_AXIS_TLAST_EN
    // Second instance with PKT_LEN=1 mirrors the same stimulus.
    fifo_rd_axis_if #(.DSIZE(DSIZE)) bus1 ();

    assign bus1.rdata    = bus.rdata;
    assign bus1.rempty   = bus.rempty;
    assign bus1.m_tready = bus.m_tready;

    fifo_rd_axis #(
        .DSIZE   (DSIZE),
        .PKT_LEN (1)
    ) dut1 (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus1)
    );
`endif

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [DSIZE-1:0] fifo_q[$];
    beat_t            sb_q[$];
    int unsigned      cnt       = 0;
    int               consumed  = 0;
    int               tlast_seen = 0;
    logic             saw_s2    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, let logic settle, check against the
    // model, record the pop/consume that the next posedge will perform.
    task automatic cycle(input logic gate, input logic tready,
                         output logic o_rinc, output logic o_tvalid,
                         output logic [DSIZE-1:0] o_tdata);
        int               occ;
        logic [DSIZE-1:0] w;
        beat_t            b;
        bus.rempty   = (fifo_q.size() == 0) || gate;
        bus.rdata    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        bus.m_tready = tready;
        #1;
        occ      = sb_q.size();
        o_rinc   = bus.rinc;
        o_tvalid = bus.m_tvalid;
        o_tdata  = bus.m_tdata;
        if (occ == 2) saw_s2 = 1'b1;
        check("rinc", {31'b0, bus.rinc}, {31'b0, (!bus.rempty && occ < 2)});
        check("tvalid", {31'b0, bus.m_tvalid}, {31'b0, (occ != 0)});
        if (occ != 0) begin
            check("tdata", {24'b0, bus.m_tdata}, {24'b0, sb_q[0].data});
            check("tlast", {31'b0, bus.m_tlast}, {31'b0, sb_q[0].last});
        end
`ifdef FIFO_RD_AXIS_TLAST_EN
        if (bus1.m_tvalid) check("tlast_len1", {31'b0, bus1.m_tlast}, 32'd1);
`endif
        if (bus.m_tvalid && bus.m_tready && occ != 0) begin
            if (bus.m_tlast) tlast_seen++;
            void'(sb_q.pop_front());
            consumed++;
        end
        if (bus.rinc && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            b.data = w;
`ifdef FIFO_RD_AXIS_TLAST_EN
            b.last = (cnt == PKT_LEN - 1);
            cnt    = b.last ? 0 : cnt + 1;
`else
            b.last = 1'b0;
`endif
            sb_q.push_back(b);
        end
        @(negedge rclk);
    endtask

    // Entered at a negedge; leaves reset released at a negedge.
    task automatic do_reset();
        rrst         = 1'b1;
        fifo_q.delete();
        sb_q.delete();
        cnt          = 0;
        consumed     = 0;
        tlast_seen   = 0;
        bus.rempty   = 1'b1;
        bus.rdata    = '0;
        bus.m_tready = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs[6];
        logic             r, v;
        logic [DSIZE-1:0] d;
        int               budget;

        // Preload 0x11..0x14, ready held high.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h11};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h12};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h13};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h14};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00};

        rrst         = 1'b1;
        bus.rempty   = 1'b1;
        bus.rdata    = '0;
        bus.m_tready = 1'b0;
        @(negedge rclk);

        // ---- Reset values, FIFO already non-empty while in reset ----
        do_reset();
        rrst = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h11 + 8'(i));
        bus.rempty = 1'b0;
        bus.rdata  = fifo_q[0];
        #1;
        check("rst_rinc", {31'b0, bus.rinc}, 32'd0);
        check("rst_tvalid", {31'b0, bus.m_tvalid}, 32'd0);
        check("rst_tdata", {24'b0, bus.m_tdata}, 32'd0);
        check("rst_tlast", {31'b0, bus.m_tlast}, 32'd0);
        @(negedge rclk);
        rrst = 1'b0;

        // ---- Table-driven preload sequence ----
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, vecs[i].tready, r, v, d);
            check($sformatf("vec%0d_rinc", i), {31'b0, r}, {31'b0, vecs[i].exp_rinc});
            check($sformatf("vec%0d_tvalid", i), {31'b0, v}, {31'b0, vecs[i].exp_tvalid});
            if (vecs[i].exp_tvalid)
                check($sformatf("vec%0d_tdata", i), {24'b0, d}, {24'b0, vecs[i].exp_tdata});
        end

        // ---- 32 beats, ready low for 3 cycles mid-stream ----
        do_reset();
        saw_s2 = 1'b0;
        for (int i = 0; i < 32; i++) fifo_q.push_back(8'h20 + 8'(i));
        budget = 0;
        while (consumed < 32 && budget < 200) begin
            cycle(1'b0, !(budget >= 10 && budget < 13), r, v, d);
            budget++;
        end
        check("stall_count", consumed, 32);
        check("stall_reached_s2", {31'b0, saw_s2}, 32'd1);
        cycle(1'b0, 1'b1, r, v, d);
        check("stall_drained", {31'b0, v}, 32'd0);

        // ---- Random rempty / m_tready, 1000 beats ----
        do_reset();
        for (int i = 0; i < 1000; i++) fifo_q.push_back(8'($urandom));
        budget = 0;
        while (consumed < 1000 && budget < 20000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, v, d);
            budget++;
        end
        check("random_count", consumed, 1000);

        // ---- 12 beats, TLAST on every PKT_LEN-th ----
        do_reset();
        for (int i = 0; i < 12; i++) fifo_q.push_back(8'h40 + 8'(i));
        budget = 0;
        while (consumed < 12 && budget < 200) begin
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), r, v, d);
            budget++;
        end
        check("pkt_count", consumed, 12);
`ifdef FIFO_RD_AXIS_TLAST_EN
        check("pkt_tlast_beats", tlast_seen, 3);
`else
        check("pkt_tlast_beats", tlast_seen, 0);
`endif

        // ---- Reset asserted while in S2 ----
        do_reset();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h60 + 8'(i));
        cycle(1'b0, 1'b1, r, v, d);
        cycle(1'b0, 1'b0, r, v, d);
        cycle(1'b0, 1'b0, r, v, d);
        check("pre_rst_s2", sb_q.size(), 2);
        rrst = 1'b1;
        #1;
        check("s2rst_tvalid", {31'b0, bus.m_tvalid}, 32'd0);
        check("s2rst_tdata", {24'b0, bus.m_tdata}, 32'd0);
        check("s2rst_tlast", {31'b0, bus.m_tlast}, 32'd0);
        check("s2rst_rinc", {31'b0, bus.rinc}, 32'd0);
        @(negedge rclk);
        do_reset();
        for (int i = 0; i < PKT_LEN; i++) fifo_q.push_back(8'h80 + 8'(i));
        budget = 0;
        while (consumed < PKT_LEN && budget < 100) begin
            cycle(1'b0, 1'b1, r, v, d);
            budget++;
        end
        check("post_rst_count", consumed, PKT_LEN);
`ifdef FIFO_RD_AXIS_TLAST_EN
        check("post_rst_tlast", tlast_seen, 1);
`else
        check("post_rst_tlast", tlast_seen, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
